// File: rtl/br_rd_sched_if.sv
`default_nettype none
// ============================================================================
// Module  : br_rd_sched_if
// Purpose : Pre-FIFO / scheduler signal bundle for br_rd_sched.
// Rev     : 1.0  initial release
// ============================================================================
interface br_rd_sched_if #(
    parameter int USEDW_W = 11
);
    logic               init_done;
    logic               fmac_rxd_en;
    logic               x_we;
    logic               wr_eof;
    logic               wr_full;
    logic               rd_empty;
    logic [USEDW_W-1:0] rdusedw;
    logic               rd_eof;
    logic               core_ready;
    logic               clr;
    logic               br_rd_en;
    logic [USEDW_W-1:0] frm_pend;
    logic [31:0]        rd_frame_cnt;
    logic               ovf_err;
    logic               udf_err;
    logic               flush_act;
    logic [1:0]         sched_st;

    modport master (
        output init_done, fmac_rxd_en, x_we, wr_eof, wr_full, rd_empty,
               rdusedw, rd_eof, core_ready, clr,
        input  br_rd_en, frm_pend, rd_frame_cnt, ovf_err, udf_err,
               flush_act, sched_st
    );

    modport slave (
        input  init_done, fmac_rxd_en, x_we, wr_eof, wr_full, rd_empty,
               rdusedw, rd_eof, core_ready, clr,
        output br_rd_en, frm_pend, rd_frame_cnt, ovf_err, udf_err,
               flush_act, sched_st
    );
endinterface
`default_nettype wire

// File: rtl/br_rd_sched.sv
`default_nettype none
// ============================================================================
// Module  : br_rd_sched
// Purpose : Frame-aware read scheduler draining a pre-FIFO into the reorder core.
// Rev     : 1.0  initial release
// ============================================================================
module br_rd_sched #(
    parameter int USEDW_W = 11,
    parameter int HI_WM   = 1000,
    parameter int TIMEOUT = 255
) (
    input  wire logic        x_clk,
    input  wire logic        reset_,
    br_rd_sched_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_READ  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    localparam logic [7:0]         c_TIMEOUT = 8'(TIMEOUT);
    localparam logic [USEDW_W-1:0] c_HI_WM   = USEDW_W'(HI_WM);

    state_t             r_state;
    logic [USEDW_W-1:0] r_frm_pend;
    logic [31:0]        r_rd_frame_cnt;
    logic               r_ovf_err;
    logic               r_udf_err;
    logic [7:0]         r_timer;

    logic w_enable;
    logic w_rd_en;
    logic w_inc;
    logic w_dec;
    logic w_pend_zero;

    assign w_enable    = bus.init_done & bus.fmac_rxd_en;
    assign w_rd_en     = ((r_state == ST_READ) || (r_state == ST_FLUSH)) &
                         ~bus.rd_empty & bus.core_ready;
    assign w_inc       = bus.x_we & bus.wr_eof & ~bus.wr_full;
    assign w_dec       = w_rd_en & bus.rd_eof;
    assign w_pend_zero = (r_frm_pend == '0);

    always_ff @(posedge x_clk) begin
        if (!reset_) begin
            r_state        <= ST_OFF;
            r_frm_pend     <= '0;
            r_rd_frame_cnt <= '0;
            r_ovf_err      <= 1'b0;
            r_udf_err      <= 1'b0;
            r_timer        <= '0;
        end else begin
            if (!w_enable) begin
                r_state <= ST_OFF;
            end else begin
                case (r_state)
                    ST_OFF:   r_state <= ST_IDLE;
                    ST_IDLE: begin
                        // A complete frame always wins over the partial-frame timeout.
                        if (!w_pend_zero || (bus.rdusedw >= c_HI_WM))
                            r_state <= ST_READ;
                        else if (!bus.rd_empty && (r_timer == c_TIMEOUT))
                            r_state <= ST_FLUSH;
                    end
                    ST_READ: begin
                        if (w_dec)
                            r_state <= ST_IDLE;
                    end
                    ST_FLUSH: begin
                        if (bus.rd_empty || w_dec)
                            r_state <= ST_IDLE;
                    end
                    default:  r_state <= ST_OFF;
                endcase
            end

            if ((r_state == ST_IDLE) && !bus.rd_empty && w_pend_zero) begin
                if (r_timer != c_TIMEOUT)
                    r_timer <= r_timer + 8'd1;
            end else begin
                r_timer <= '0;
            end

            // Coincident increment and decrement cancel, so neither saturation rule applies.
            if (w_inc && !w_dec) begin
                if (r_frm_pend != '1)
                    r_frm_pend <= r_frm_pend + 1'b1;
            end else if (w_dec && !w_inc) begin
                if (!w_pend_zero)
                    r_frm_pend <= r_frm_pend - 1'b1;
            end

            if (bus.clr)
                r_udf_err <= 1'b0;
            else if (w_dec && !w_inc && w_pend_zero)
                r_udf_err <= 1'b1;

            if (bus.clr)
                r_ovf_err <= 1'b0;
            else if (bus.x_we && bus.wr_full)
                r_ovf_err <= 1'b1;

            if (bus.clr)
                r_rd_frame_cnt <= '0;
            else if (w_dec)
                r_rd_frame_cnt <= r_rd_frame_cnt + 32'd1;
        end
    end

    assign bus.br_rd_en     = w_rd_en;
    assign bus.frm_pend     = r_frm_pend;
    assign bus.rd_frame_cnt = r_rd_frame_cnt;
    assign bus.ovf_err      = r_ovf_err;
    assign bus.udf_err      = r_udf_err;
    assign bus.flush_act    = (r_state == ST_FLUSH);
    assign bus.sched_st     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_br_rd_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_br_rd_sched
// Purpose : Directed self-checking bench with a pre-FIFO model and frame scoreboard.
// Rev     : 1.0  initial release
// ============================================================================
module tb_br_rd_sched;

    localparam int USEDW_W = 11;

    logic x_clk;
    logic reset_;

    br_rd_sched_if #(.USEDW_W(USEDW_W)) bus ();

    br_rd_sched #(
        .USEDW_W (USEDW_W),
        .HI_WM   (1000),
        .TIMEOUT (255)
    ) dut (
        .x_clk  (x_clk),
        .reset_ (reset_),
        .bus    (bus)
    );

    initial begin
        x_clk = 1'b0;
        forever #5 x_clk = ~x_clk;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pre-FIFO model: actions are captured mid-cycle and applied on the edge.
    logic fq[$];
    int   sb[$];
    int   mon_words = 0;
    logic m_rd = 1'b0, m_wr = 1'b0, m_weof = 1'b0;
    logic m_clr = 1'b1, m_bd = 1'b0;

    always @(negedge x_clk) begin
        m_rd   = (bus.br_rd_en === 1'b1);
        m_wr   = (bus.x_we === 1'b1) && (bus.wr_full === 1'b0);
        m_weof = bus.wr_eof;
        if (bus.br_rd_en === 1'b1) begin
            mon_words++;
            if (bus.rd_eof === 1'b1) begin
                check("sb_avail", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0)
                    check("frame_len", 32'(mon_words), 32'(sb.pop_front()));
                mon_words = 0;
            end
        end
    end

    always @(posedge x_clk) begin
        if (m_clr) begin
            fq.delete();
        end else begin
            if (m_rd && fq.size() > 0) void'(fq.pop_front());
            if (m_wr) fq.push_back(m_weof);
            if (m_bd) fq.push_back(1'b1);
        end
        bus.rd_empty <= (fq.size() == 0);
        bus.rdusedw  <= 11'(fq.size());
        bus.rd_eof   <= (fq.size() > 0) ? fq[0] : 1'b0;
    end

    task automatic tick();
        @(posedge x_clk);
        #1;
    endtask

    task automatic write_frame(input int len, input logic eof);
        if (eof) sb.push_back(len);
        for (int i = 0; i < len; i++) begin
            bus.x_we   = 1'b1;
            bus.wr_eof = eof && (i == len - 1);
            tick();
        end
        bus.x_we   = 1'b0;
        bus.wr_eof = 1'b0;
    endtask

    task automatic wait_state(input string tag, input logic [1:0] st, input int max_cyc);
        int k = 0;
        while (bus.sched_st !== st && k < max_cyc) begin
            tick();
            k++;
        end
        check(tag, 32'(bus.sched_st), 32'(st));
    endtask

    task automatic wait_drained(input string tag, input int max_cyc);
        int k = 0;
        while (!(bus.frm_pend === '0 && bus.sched_st === 2'd1) && k < max_cyc) begin
            tick();
            k++;
        end
        check(tag, 32'(k < max_cyc), 32'd1);
    endtask

    initial begin
        int n;
        int k;

        reset_          = 1'b0;
        bus.init_done   = 1'b0;
        bus.fmac_rxd_en = 1'b0;
        bus.x_we        = 1'b0;
        bus.wr_eof      = 1'b0;
        bus.wr_full     = 1'b0;
        bus.core_ready  = 1'b0;
        bus.clr         = 1'b0;
        repeat (3) tick();
        m_clr = 1'b0;

        check("rst_state", 32'(bus.sched_st), 32'd0);
        check("rst_pend", 32'(bus.frm_pend), 32'd0);
        check("rst_cnt", bus.rd_frame_cnt, 32'd0);
        check("rst_ovf", 32'(bus.ovf_err), 32'd0);
        check("rst_udf", 32'(bus.udf_err), 32'd0);
        check("rst_rden", 32'(bus.br_rd_en), 32'd0);

        reset_ = 1'b1;
        tick();
        check("off_hold", 32'(bus.sched_st), 32'd0);
        bus.init_done   = 1'b1;
        bus.fmac_rxd_en = 1'b1;
        bus.core_ready  = 1'b1;
        tick();
        check("off_to_idle", 32'(bus.sched_st), 32'd1);

        // One complete frame
        write_frame(4, 1'b1);
        check("f1_pend1", 32'(bus.frm_pend), 32'd1);
        check("f1_idle", 32'(bus.sched_st), 32'd1);
        tick();
        check("f1_read", 32'(bus.sched_st), 32'd2);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            n += int'(bus.br_rd_en);
            tick();
        end
        check("f1_reads", 32'(n), 32'd4);
        check("f1_back_idle", 32'(bus.sched_st), 32'd1);
        check("f1_pend0", 32'(bus.frm_pend), 32'd0);
        check("f1_cnt", bus.rd_frame_cnt, 32'd1);
        check("f1_rden_off", 32'(bus.br_rd_en), 32'd0);

        // Backpressure: reads track core_ready cycle by cycle
        bus.core_ready = 1'b0;
        write_frame(4, 1'b1);
        tick();
        check("bp_read", 32'(bus.sched_st), 32'd2);
        check("bp_stalled", 32'(bus.br_rd_en), 32'd0);
        for (int i = 0; i < 8; i++) begin
            bus.core_ready = (i % 2 == 0);
            #1;
            check("bp_follow", 32'(bus.br_rd_en), 32'(bus.core_ready));
            tick();
        end
        check("bp_cnt", bus.rd_frame_cnt, 32'd2);
        check("bp_idle", 32'(bus.sched_st), 32'd1);
        check("bp_pend", 32'(bus.frm_pend), 32'd0);
        bus.core_ready = 1'b1;

        // Partial frame flushed after the idle timeout
        write_frame(3, 1'b0);
        k = 0;
        while (bus.flush_act !== 1'b1 && k < 400) begin
            tick();
            k++;
        end
        check("to_flush", 32'(bus.flush_act), 32'd1);
        check("to_state", 32'(bus.sched_st), 32'd3);
        check("to_delay", 32'(k >= 250 && k <= 260), 32'd1);
        n = 0;
        k = 0;
        while (bus.flush_act === 1'b1 && k < 20) begin
            n += int'(bus.br_rd_en);
            tick();
            k++;
        end
        check("to_reads", 32'(n), 32'd3);
        check("to_idle", 32'(bus.sched_st), 32'd1);
        check("to_pend", 32'(bus.frm_pend), 32'd0);
        check("to_cnt", bus.rd_frame_cnt, 32'd2);
        mon_words = 0;

        // EOF word that was never counted in: flush reads it and underflows
        m_bd = 1'b1;
        sb.push_back(1);
        tick();
        m_bd = 1'b0;
        wait_state("udf_flush", 2'd3, 400);
        wait_state("udf_idle", 2'd1, 10);
        check("udf_flag", 32'(bus.udf_err), 32'd1);
        check("udf_pend", 32'(bus.frm_pend), 32'd0);
        check("udf_cnt", bus.rd_frame_cnt, 32'd3);

        // Overflow and clear
        bus.core_ready = 1'b0;
        write_frame(2, 1'b1);
        bus.wr_full = 1'b1;
        bus.x_we    = 1'b1;
        bus.wr_eof  = 1'b1;
        tick();
        check("ovf_set", 32'(bus.ovf_err), 32'd1);
        check("ovf_pend", 32'(bus.frm_pend), 32'd1);
        bus.clr = 1'b1;
        tick();
        bus.clr     = 1'b0;
        bus.x_we    = 1'b0;
        bus.wr_eof  = 1'b0;
        bus.wr_full = 1'b0;
        check("clr_ovf", 32'(bus.ovf_err), 32'd0);
        check("clr_udf", 32'(bus.udf_err), 32'd0);
        check("clr_cnt", bus.rd_frame_cnt, 32'd0);
        check("clr_pend", 32'(bus.frm_pend), 32'd1);
        check("clr_state", 32'(bus.sched_st), 32'd2);
        bus.core_ready = 1'b1;
        wait_drained("ovf_drain", 40);
        check("ovf_cnt", bus.rd_frame_cnt, 32'd1);

        // Write EOF and read EOF on the same edge
        bus.core_ready = 1'b0;
        write_frame(2, 1'b1);
        write_frame(2, 1'b1);
        check("sim_pend2", 32'(bus.frm_pend), 32'd2);
        check("sim_read", 32'(bus.sched_st), 32'd2);
        sb.push_back(2);
        bus.core_ready = 1'b1;
        bus.x_we       = 1'b1;
        tick();
        bus.wr_eof = 1'b1;
        tick();
        bus.x_we   = 1'b0;
        bus.wr_eof = 1'b0;
        check("sim_pend", 32'(bus.frm_pend), 32'd2);
        check("sim_cnt", bus.rd_frame_cnt, 32'd2);
        wait_drained("sim_drain", 60);
        check("sim_cnt_end", bus.rd_frame_cnt, 32'd4);

        // Reset in the middle of a frame
        bus.core_ready = 1'b0;
        write_frame(5, 1'b1);
        wait_state("rm_read", 2'd2, 10);
        bus.core_ready = 1'b1;
        tick();
        tick();
        reset_ = 1'b0;
        tick();
        check("rm_state", 32'(bus.sched_st), 32'd0);
        check("rm_rden", 32'(bus.br_rd_en), 32'd0);
        check("rm_pend", 32'(bus.frm_pend), 32'd0);
        check("rm_cnt", bus.rd_frame_cnt, 32'd0);
        reset_ = 1'b1;
        m_clr  = 1'b1;
        sb.delete();
        mon_words = 0;
        tick();
        m_clr = 1'b0;
        check("rm_idle", 32'(bus.sched_st), 32'd1);

        // Disable in the middle of a frame, then resume it
        bus.core_ready = 1'b0;
        write_frame(5, 1'b1);
        wait_state("dis_read", 2'd2, 10);
        bus.core_ready = 1'b1;
        tick();
        tick();
        bus.fmac_rxd_en = 1'b0;
        tick();
        check("dis_state", 32'(bus.sched_st), 32'd0);
        check("dis_pend", 32'(bus.frm_pend), 32'd1);
        check("dis_rden", 32'(bus.br_rd_en), 32'd0);
        bus.fmac_rxd_en = 1'b1;
        wait_drained("dis_drain", 40);
        check("dis_cnt", bus.rd_frame_cnt, 32'd1);
        check("sb_left", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
